// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared definitions for the data-memory bridge.
// Holds funct3 size encodings, the bridge FSM states and a size helper.
package dmem_bridge_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_D  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;
    localparam logic [2:0] SZ_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RSP,
        S_DONE
    } state_t;

    // Access size in bytes; 0 marks an encoding with no defined size.
    function automatic logic [3:0] size_bytes(input logic [2:0] size);
        case (size)
            SZ_B, SZ_BU: size_bytes = 4'd1;
            SZ_H, SZ_HU: size_bytes = 4'd2;
            SZ_W, SZ_WU: size_bytes = 4'd4;
            SZ_D:        size_bytes = 4'd8;
            default:     size_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// lane_align: combinational byte-lane steering for dmem_bridge.
// Ports: Size/Offset select the access; Wdata -> Wdata_rep and Be for
// stores; Rdata -> Rdata_ext for loads; Illegal/Misaligned flag bad
// accesses.
module lane_align
    import dmem_bridge_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]                    Size,
    input  logic [$clog2(DATA_W/8)-1:0]   Offset,
    input  logic [DATA_W-1:0]             Wdata,
    input  logic [DATA_W-1:0]             Rdata,
    output logic [DATA_W-1:0]             Wdata_rep,
    output logic [DATA_W/8-1:0]           Be,
    output logic [DATA_W-1:0]             Rdata_ext,
    output logic                          Illegal,
    output logic                          Misaligned
);

    localparam int BE_W = DATA_W / 8;

    logic [3:0]        nbytes;
    logic [BE_W-1:0]   mask;
    logic [DATA_W-1:0] shifted;

    assign nbytes = size_bytes(Size);

    always_comb begin
        Illegal = 1'b0;
        unique case (Size)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: Illegal = 1'b0;
            SZ_D, SZ_WU: Illegal = (DATA_W != 64);
            default: Illegal = 1'b1;
        endcase
    end

    // Aligned when the offset has no bits below the access size.
    assign Misaligned = ((4'(Offset) & (nbytes - 4'd1)) != 4'd0);

    always_comb begin
        mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            mask[i] = (4'(i) < nbytes);
        end
    end

    assign Be = mask << Offset;

    always_comb begin
        Wdata_rep = Wdata;
        unique case (nbytes)
            4'd1: Wdata_rep = {BE_W{Wdata[7:0]}};
            4'd2: Wdata_rep = {(BE_W/2){Wdata[15:0]}};
            4'd4: Wdata_rep = {(DATA_W/32){Wdata[31:0]}};
            default: Wdata_rep = Wdata;
        endcase
    end

    assign shifted = Rdata >> {Offset, 3'b000};

    always_comb begin
        Rdata_ext = shifted;
        unique case (Size)
            SZ_B:  Rdata_ext = DATA_W'($signed(shifted[7:0]));
            SZ_H:  Rdata_ext = DATA_W'($signed(shifted[15:0]));
            SZ_W:  Rdata_ext = DATA_W'($signed(shifted[31:0]));
            SZ_BU: Rdata_ext = DATA_W'(shifted[7:0]);
            SZ_HU: Rdata_ext = DATA_W'(shifted[15:0]);
            SZ_WU: Rdata_ext = DATA_W'(shifted[31:0]);
            default: Rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: MEM-stage load/store bridge to a req/gnt/rvalid memory.
// Ports: Req_* from MEM stage, Rsp_* completion back, Stall_o holds the
// pipeline, Flush_i drops the response, Dmem_* drive the data bus.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Req_valid_i,
    input  logic                Req_we_i,
    input  logic [2:0]          Req_size_i,
    input  logic [ADDR_W-1:0]   Req_addr_i,
    input  logic [DATA_W-1:0]   Req_wdata_i,
    output logic                Req_ready_o,
    output logic                Rsp_valid_o,
    output logic [DATA_W-1:0]   Rsp_rdata_o,
    output logic                Rsp_err_o,
    output logic                Stall_o,
    input  logic                Flush_i,
    output logic                Dmem_req_o,
    output logic                Dmem_we_o,
    output logic [ADDR_W-1:0]   Dmem_addr_o,
    output logic [DATA_W-1:0]   Dmem_wdata_o,
    output logic [DATA_W/8-1:0] Dmem_be_o,
    input  logic                Dmem_gnt_i,
    input  logic                Dmem_rvalid_i,
    input  logic [DATA_W-1:0]   Dmem_rdata_i
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int TC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT - 1);

    state_t              state;
    logic [ADDR_W-1:0]   a_addr;
    logic                a_we;
    logic [2:0]          a_size;
    logic [DATA_W-1:0]   a_wdata;
    logic                drop;
    logic [TC_W-1:0]     tcnt;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic                idle;
    logic                in_req;
    logic                timeout_hit;
    logic                drop_now;
    logic [2:0]          cur_size;
    logic [OFF_W-1:0]    cur_off;
    logic [DATA_W-1:0]   cur_wdata;
    logic [DATA_W-1:0]   wdata_rep;
    logic [BE_W-1:0]     be;
    logic [DATA_W-1:0]   rdata_ext;
    logic                illegal;
    logic                misaligned;

    assign idle   = (state == S_IDLE);
    assign in_req = (state == S_REQ);

    // One aligner serves both phases: the incoming request is checked in
    // IDLE, the latched access drives lanes and extraction afterwards.
    assign cur_size  = idle ? Req_size_i : a_size;
    assign cur_off   = idle ? Req_addr_i[OFF_W-1:0] : a_addr[OFF_W-1:0];
    assign cur_wdata = idle ? Req_wdata_i : a_wdata;

    lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .Size       (cur_size),
        .Offset     (cur_off),
        .Wdata      (cur_wdata),
        .Rdata      (Dmem_rdata_i),
        .Wdata_rep  (wdata_rep),
        .Be         (be),
        .Rdata_ext  (rdata_ext),
        .Illegal    (illegal),
        .Misaligned (misaligned)
    );

    assign timeout_hit = (TIMEOUT != 0) && (tcnt == TC_LAST);
    assign drop_now    = drop | Flush_i;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            a_addr      <= '0;
            a_we        <= 1'b0;
            a_size      <= '0;
            a_wdata     <= '0;
            drop        <= 1'b0;
            tcnt        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    drop <= 1'b0;
                    if (Req_valid_i) begin
                        tcnt        <= '0;
                        rsp_rdata_q <= '0;
                        if (illegal || misaligned) begin
                            state       <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state   <= S_REQ;
                            a_addr  <= Req_addr_i;
                            a_we    <= Req_we_i;
                            a_size  <= Req_size_i;
                            a_wdata <= Req_wdata_i;
                        end
                    end
                end
                S_REQ: begin
                    tcnt <= tcnt + TC_W'(1);
                    drop <= drop_now;
                    // rvalid alongside gnt is not a response.
                    if (timeout_hit) begin
                        state       <= S_DONE;
                        rsp_valid_q <= !drop_now;
                        rsp_err_q   <= !drop_now;
                    end else if (Dmem_gnt_i) begin
                        state <= S_RSP;
                    end
                end
                S_RSP: begin
                    tcnt <= tcnt + TC_W'(1);
                    drop <= drop_now;
                    if (Dmem_rvalid_i) begin
                        state       <= S_DONE;
                        rsp_valid_q <= !drop_now;
                        rsp_rdata_q <= a_we ? '0 : rdata_ext;
                    end else if (timeout_hit) begin
                        state       <= S_DONE;
                        rsp_valid_q <= !drop_now;
                        rsp_err_q   <= !drop_now;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    drop  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Req_ready_o = idle;
    assign Rsp_valid_o = rsp_valid_q;
    assign Rsp_err_o   = rsp_err_q;
    assign Rsp_rdata_o = rsp_rdata_q;
    assign Stall_o     = in_req || (state == S_RSP) || (idle && Req_valid_i);

    assign Dmem_req_o   = in_req;
    assign Dmem_we_o    = in_req && a_we;
    assign Dmem_addr_o  = in_req ? {a_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign Dmem_wdata_o = in_req ? wdata_rep : '0;
    assign Dmem_be_o    = in_req ? be : '0;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed scoreboard bench for dmem_bridge.
// Drives accesses with hand-computed expectations; a monitor checks Rsp_*.
module tb_dmem_bridge;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req_valid_i = 1'b0;
    logic        Req_we_i = 1'b0;
    logic [2:0]  Req_size_i = '0;
    logic [31:0] Req_addr_i = '0;
    logic [31:0] Req_wdata_i = '0;
    logic        Req_ready_o;
    logic        Rsp_valid_o;
    logic [31:0] Rsp_rdata_o;
    logic        Rsp_err_o;
    logic        Stall_o;
    logic        Flush_i = 1'b0;
    logic        Dmem_req_o;
    logic        Dmem_we_o;
    logic [31:0] Dmem_addr_o;
    logic [31:0] Dmem_wdata_o;
    logic [3:0]  Dmem_be_o;
    logic        Dmem_gnt_i = 1'b0;
    logic        Dmem_rvalid_i = 1'b0;
    logic [31:0] Dmem_rdata_i = '0;

    dmem_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Req_valid_i   (Req_valid_i),
        .Req_we_i      (Req_we_i),
        .Req_size_i    (Req_size_i),
        .Req_addr_i    (Req_addr_i),
        .Req_wdata_i   (Req_wdata_i),
        .Req_ready_o   (Req_ready_o),
        .Rsp_valid_o   (Rsp_valid_o),
        .Rsp_rdata_o   (Rsp_rdata_o),
        .Rsp_err_o     (Rsp_err_o),
        .Stall_o       (Stall_o),
        .Flush_i       (Flush_i),
        .Dmem_req_o    (Dmem_req_o),
        .Dmem_we_o     (Dmem_we_o),
        .Dmem_addr_o   (Dmem_addr_o),
        .Dmem_wdata_o  (Dmem_wdata_o),
        .Dmem_be_o     (Dmem_be_o),
        .Dmem_gnt_i    (Dmem_gnt_i),
        .Dmem_rvalid_i (Dmem_rvalid_i),
        .Dmem_rdata_i  (Dmem_rdata_i)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] rdata, input logic err);
        exp_q.push_back('{rdata: rdata, err: err});
    endtask

    // Monitor: every response pulse must match the oldest expectation.
    initial forever begin
        @(negedge Clk);
        if (Reset_n && Rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rdata %h err %b expected none",
                         Rsp_rdata_o, Rsp_err_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_err", 32'(Rsp_err_o), 32'(mon_e.err));
                if (!mon_e.err) chk("rsp_rdata", Rsp_rdata_o, mon_e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    task automatic drive_req(input logic we, input logic [2:0] sz,
                             input logic [31:0] addr, input logic [31:0] wd);
        @(posedge Clk);
        #1;
        Req_valid_i = 1'b1;
        Req_we_i    = we;
        Req_size_i  = sz;
        Req_addr_i  = addr;
        Req_wdata_i = wd;
    endtask

    task automatic chk_bus(input string tag, input logic we,
                           input logic [31:0] e_addr, input logic [31:0] e_wd,
                           input logic [3:0] e_be);
        chk({tag, "_req"}, 32'(Dmem_req_o), 32'd1);
        chk({tag, "_we"}, 32'(Dmem_we_o), 32'(we));
        chk({tag, "_addr"}, Dmem_addr_o, e_addr);
        chk({tag, "_wdata"}, Dmem_wdata_o, e_wd);
        chk({tag, "_be"}, 32'(Dmem_be_o), 32'(e_be));
        chk({tag, "_stall"}, 32'(Stall_o), 32'd1);
    endtask

    task automatic run_access(input string tag, input logic we,
                              input logic [2:0] sz, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] mrd,
                              input int gnt_wait, input bit early_rv,
                              input bit flush, input logic [31:0] e_addr,
                              input logic [31:0] e_wd, input logic [3:0] e_be);
        drive_req(we, sz, addr, wd);
        @(negedge Clk);
        chk({tag, "_t0_stall"}, 32'(Stall_o), 32'd1);
        chk({tag, "_t0_ready"}, 32'(Req_ready_o), 32'd1);
        chk({tag, "_t0_req"}, 32'(Dmem_req_o), 32'd0);
        @(posedge Clk);
        #1;
        Req_valid_i = 1'b0;
        Req_wdata_i = 32'h0;
        for (int i = 0; i < gnt_wait; i++) begin
            Dmem_gnt_i = 1'b0;
            @(negedge Clk);
            chk_bus({tag, "_wait"}, we, e_addr, e_wd, e_be);
            @(posedge Clk);
            #1;
        end
        Dmem_gnt_i    = 1'b1;
        Dmem_rvalid_i = early_rv;
        Dmem_rdata_i  = 32'hBAD0BAD0;
        @(negedge Clk);
        chk_bus({tag, "_gnt"}, we, e_addr, e_wd, e_be);
        @(posedge Clk);
        #1;
        Dmem_gnt_i    = 1'b0;
        Dmem_rvalid_i = 1'b0;
        if (early_rv || flush) begin
            Flush_i = flush;
            @(negedge Clk);
            chk({tag, "_rspwait_stall"}, 32'(Stall_o), 32'd1);
            @(posedge Clk);
            #1;
            Flush_i = 1'b0;
        end
        Dmem_rvalid_i = 1'b1;
        Dmem_rdata_i  = mrd;
        @(negedge Clk);
        chk({tag, "_rsp_stall"}, 32'(Stall_o), 32'd1);
        chk({tag, "_rsp_req"}, 32'(Dmem_req_o), 32'd0);
        @(posedge Clk);
        #1;
        Dmem_rvalid_i = 1'b0;
        Dmem_rdata_i  = 32'h0;
        @(negedge Clk);
        chk({tag, "_done_stall"}, 32'(Stall_o), 32'd0);
        chk({tag, "_done_ready"}, 32'(Req_ready_o), 32'd0);
        chk({tag, "_done_valid"}, 32'(Rsp_valid_o), 32'(!flush));
        @(posedge Clk);
        #1;
        @(negedge Clk);
        chk({tag, "_idle_ready"}, 32'(Req_ready_o), 32'd1);
    endtask

    task automatic err_access(input string tag, input logic we,
                              input logic [2:0] sz, input logic [31:0] addr);
        push(32'h0, 1'b1);
        drive_req(we, sz, addr, 32'h0);
        @(negedge Clk);
        chk({tag, "_t0_stall"}, 32'(Stall_o), 32'd1);
        chk({tag, "_t0_req"}, 32'(Dmem_req_o), 32'd0);
        @(posedge Clk);
        #1;
        Req_valid_i = 1'b0;
        @(negedge Clk);
        chk({tag, "_t1_valid"}, 32'(Rsp_valid_o), 32'd1);
        chk({tag, "_t1_req"}, 32'(Dmem_req_o), 32'd0);
        chk({tag, "_t1_stall"}, 32'(Stall_o), 32'd0);
        chk({tag, "_t1_ready"}, 32'(Req_ready_o), 32'd0);
        @(posedge Clk);
        #1;
        @(negedge Clk);
        chk({tag, "_idle_ready"}, 32'(Req_ready_o), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        chk("rst_ready", 32'(Req_ready_o), 32'd1);
        chk("rst_valid", 32'(Rsp_valid_o), 32'd0);
        chk("rst_stall", 32'(Stall_o), 32'd0);
        chk("rst_req", 32'(Dmem_req_o), 32'd0);
        chk("rst_be", 32'(Dmem_be_o), 32'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        push(32'hDEADBEEF, 1'b0);
        run_access("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF,
                   0, 1'b0, 1'b0, 32'h100, 32'h0, 4'b1111);
        push(32'h0, 1'b0);
        run_access("sb", 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,
                   0, 1'b0, 1'b0, 32'h100, 32'hA5A5A5A5, 4'b1000);
        push(32'hFFFF8001, 1'b0);
        run_access("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234,
                   0, 1'b0, 1'b0, 32'h100, 32'h0, 4'b1100);
        push(32'h00008001, 1'b0);
        run_access("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234,
                   0, 1'b0, 1'b0, 32'h100, 32'h0, 4'b1100);
        push(32'h0, 1'b0);
        run_access("sh", 1'b1, 3'b001, 32'h102, 32'hFFFF1234, 32'h0,
                   2, 1'b0, 1'b0, 32'h100, 32'h12341234, 4'b1100);
        push(32'hFFFFFF80, 1'b0);
        run_access("lb", 1'b0, 3'b000, 32'h101, 32'h0, 32'h00008000,
                   0, 1'b1, 1'b0, 32'h100, 32'h0, 4'b0010);
        push(32'h00000012, 1'b0);
        run_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h12345678,
                   1, 1'b0, 1'b0, 32'h100, 32'h0, 4'b1000);
        push(32'h0, 1'b0);
        run_access("sw", 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0,
                   0, 1'b0, 1'b0, 32'h104, 32'hCAFEF00D, 4'b1111);

        err_access("lw_mis", 1'b0, 3'b010, 32'h102);
        err_access("sh_mis", 1'b1, 3'b001, 32'h101);
        err_access("ld_ill", 1'b0, 3'b011, 32'h100);
        err_access("lwu_ill", 1'b0, 3'b110, 32'h100);
        err_access("sz7_ill", 1'b0, 3'b111, 32'h100);

        // Timeout: gnt given, rvalid withheld; error lands 9 cycles on.
        push(32'h0, 1'b1);
        drive_req(1'b0, 3'b010, 32'h200, 32'h0);
        @(posedge Clk);
        #1;
        Req_valid_i = 1'b0;
        Dmem_gnt_i  = 1'b1;
        @(negedge Clk);
        chk("to_req", 32'(Dmem_req_o), 32'd1);
        @(posedge Clk);
        #1;
        Dmem_gnt_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge Clk);
            chk("to_wait_stall", 32'(Stall_o), 32'd1);
            chk("to_wait_valid", 32'(Rsp_valid_o), 32'd0);
            @(posedge Clk);
            #1;
        end
        Dmem_rvalid_i = 1'b1;
        Dmem_rdata_i  = 32'h55555555;
        @(negedge Clk);
        chk("to_done_valid", 32'(Rsp_valid_o), 32'd1);
        chk("to_done_req", 32'(Dmem_req_o), 32'd0);
        repeat (2) begin
            @(posedge Clk);
            #1;
            @(negedge Clk);
            chk("to_late_ready", 32'(Req_ready_o), 32'd1);
            chk("to_late_valid", 32'(Rsp_valid_o), 32'd0);
        end
        @(posedge Clk);
        #1;
        Dmem_rvalid_i = 1'b0;
        Dmem_rdata_i  = 32'h0;

        // Flush in RSP: no response, then the bridge accepts again.
        run_access("flush", 1'b0, 3'b010, 32'h300, 32'h0, 32'h11111111,
                   0, 1'b0, 1'b1, 32'h300, 32'h0, 4'b1111);
        push(32'h01020304, 1'b0);
        run_access("post", 1'b0, 3'b010, 32'h100, 32'h0, 32'h01020304,
                   0, 1'b0, 1'b0, 32'h100, 32'h0, 4'b1111);

        // Reset mid-access drops the bus request at once.
        drive_req(1'b0, 3'b010, 32'h400, 32'h0);
        @(posedge Clk);
        #1;
        Req_valid_i = 1'b0;
        @(negedge Clk);
        chk("mid_req", 32'(Dmem_req_o), 32'd1);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(Dmem_req_o), 32'd0);
        chk("mid_rst_ready", 32'(Req_ready_o), 32'd1);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("mid_after_ready", 32'(Req_ready_o), 32'd1);
        chk("mid_after_req", 32'(Dmem_req_o), 32'd0);

        repeat (2) @(negedge Clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
